pll_lock_ctrl: RTL and testbench

//  Bring-up and supervisory controller for the 3.072 MHz audio PLL.
//  - Pulses the PLL reset and waits for a stable lock, with timeout and bounded retries.
//  - Releases the downstream audio-domain reset only after lock has held stable.
//  - Re-sequences the PLL on loss of lock or a software restart.

---
 rtl/pll_lock_ctrl_pkg.sv | 27 ++
 rtl/pll_lock_ctrl_sync_2ff.sv | 30 +++
 rtl/pll_lock_ctrl.sv | 152 +++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// pll_ctrl_pkg: shared definitions for the audio PLL lock controller.
//   pll_state_e : FSM state encoding (also exported on state_dbg)
//   retry_w()   : width of the retry counter for a given MAX_RETRIES
//   timer_w()   : width of the single state timer covering all timed states
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAULT      = 3'd4
    } pll_state_e;

    function automatic int retry_w(input int max_retries);
        return $clog2(max_retries + 1);
    endfunction

    function automatic int timer_w(input int hold, input int timeout, input int stable);
        int m;
        m = hold;
        if (timeout > m) m = timeout;
        if (stable > m) m = stable;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for signals asynchronous to clk.
//   clk   in  clock of the destination domain
//   rst_n in  asynchronous active-low reset, clears both flops
//   d_i   in  asynchronous input
//   q_o   out synchronized output, two clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: bring-up and supervisory controller for the audio PLL.
// Pulses the PLL reset, waits for a stable lock (with timeout and bounded
// retries), then releases the audio-domain reset. Re-sequences on loss of
// lock or a software restart.
//   refclk      in  reference clock, the only clock
//   rst_n       in  asynchronous active-low reset
//   pll_locked  in  PLL lock flag, asynchronous to refclk
//   restart_req in  single-cycle request to re-sequence the PLL
//   pll_rst     out active-high PLL reset
//   out_rst_n   out active-low reset for the audio-clock domain
//   ready       out high only in RUN
//   fault       out sticky: retries exhausted
//   retry_cnt   out failed attempts since last success
//   lost_cnt    out loss-of-lock events in RUN, saturating at 255
//   state_dbg   out current state encoding
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 4
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               restart_req,
    output logic                               pll_rst,
    output logic                               out_rst_n,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [7:0]                         lost_cnt,
    output logic [2:0]                         state_dbg
);

    localparam int RW = retry_w(MAX_RETRIES);
    localparam int TW = timer_w(RST_HOLD_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);

    // Timer values on the last cycle of each timed state.
    localparam logic [TW-1:0] HOLD_LAST   = TW'(RST_HOLD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

    logic          locked_s;
    pll_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic          pll_rst_q, pll_rst_d;
    logic          out_rst_n_q, out_rst_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk  (refclk),
        .rst_n(rst_n),
        .d_i  (pll_locked),
        .q_o  (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        lost_d  = lost_q;

        if (restart_req) begin
            // Restart overrides everything, including a same-cycle lock drop in RUN.
            state_d = ST_RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RESET_PLL: begin
                    if (timer_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE_CHK;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 1'b1;
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                    end
                end
                ST_STABLE_CHK: begin
                    // A drop here is not charged as a retry; just wait for lock again.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                        if (lost_q != 8'hFF) lost_d = lost_q + 1'b1;
                    end
                end
                ST_FAULT: ;
                default: state_d = ST_RESET_PLL;
            endcase
        end

        // Cleared on every state entry (restart counts as re-entry). Timed
        // states always exit at their last count, so the timer cannot wrap.
        if (restart_req || (state_d != state_q)) begin
            timer_d = '0;
        end else if (state_q == ST_RUN || state_q == ST_FAULT) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // Outputs are decoded from the next state so they switch with state_q.
        pll_rst_d   = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
        out_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        fault_d     = (state_d == ST_FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET_PLL;
            timer_q     <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            out_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            out_rst_n_q <= out_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign out_rst_n = out_rst_n_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign lost_cnt  = lost_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench: every expected state change (new state, edge number) is
// queued when the stimulus that causes it is driven; a negedge monitor pops
// and compares each observed state_dbg change and the outputs implied by it.
module tb_pll_lock_ctrl;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       out_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;
    logic [2:0] state_dbg;

    pll_lock_ctrl #(
        .RST_HOLD_CYC    (4),
        .LOCK_TIMEOUT_CYC(20),
        .LOCK_STABLE_CYC (8),
        .MAX_RETRIES     (2)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .restart_req(restart_req),
        .pll_rst    (pll_rst),
        .out_rst_n  (out_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .lost_cnt   (lost_cnt),
        .state_dbg  (state_dbg)
    );

    typedef struct {
        int st;
        int cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    bit         mon_en = 0;
    logic [2:0] prev_st;

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int st, input int c);
        exp_t e;
        e.st  = st;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    always @(negedge refclk) begin
        exp_t e;
        if (mon_en && state_dbg !== prev_st) begin
            if (sb.size() == 0) begin
                chk("unexpected_state", int'(state_dbg), 7);
            end else begin
                e = sb.pop_front();
                chk("state", int'(state_dbg), e.st);
                chk("state_edge", cyc, e.cyc);
                chk("pll_rst", int'(pll_rst), int'(e.st == 0 || e.st == 4));
                chk("ready", int'(ready), int'(e.st == 3));
                chk("out_rst_n", int'(out_rst_n), int'(e.st == 3));
                chk("fault", int'(fault), int'(e.st == 4));
            end
            prev_st = state_dbg;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, k, r, q, t;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        restart_req = 1'b0;
        repeat (2) @(negedge refclk);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_out_rst_n", int'(out_rst_n), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        chk("rst_lost", int'(lost_cnt), 0);
        prev_st = state_dbg;
        mon_en = 1;

        // Clean bring-up: lock sampled from edge 6.
        b = cyc;
        push(1, b + 4);
        push(2, b + 8);
        push(3, b + 16);
        rst_n = 1'b1;
        wait_cyc(b + 5);
        pll_locked = 1'b1;
        wait_cyc(b + 17);
        chk("up_retry", int'(retry_cnt), 0);
        chk("up_ready", int'(ready), 1);

        // Loss of lock in RUN, lock stays away: two timeouts then FAULT.
        k = b + 20;
        wait_cyc(k);
        pll_locked = 1'b0;
        push(0, k + 3);
        push(1, k + 7);
        push(0, k + 27);
        push(1, k + 31);
        push(4, k + 51);
        wait_cyc(k + 4);
        chk("lost_after_drop", int'(lost_cnt), 1);
        wait_cyc(k + 28);
        chk("retry_first", int'(retry_cnt), 1);
        wait_cyc(k + 60);
        chk("fault_sticky", int'(fault), 1);
        chk("fault_retry", int'(retry_cnt), 2);
        chk("fault_pll_rst", int'(pll_rst), 1);

        // Restart out of FAULT.
        restart_req = 1'b1;
        r = k + 61;
        push(0, r);
        push(1, r + 4);
        wait_cyc(r);
        restart_req = 1'b0;
        chk("restart_fault", int'(fault), 0);
        chk("restart_retry", int'(retry_cnt), 0);

        // Unstable lock: high 5 cycles, low 1, then high.
        wait_cyc(r + 4);
        pll_locked = 1'b1;
        push(2, r + 7);
        push(1, r + 12);
        push(2, r + 13);
        push(3, r + 21);
        wait_cyc(r + 9);
        pll_locked = 1'b0;
        wait_cyc(r + 10);
        pll_locked = 1'b1;
        wait_cyc(r + 12);
        chk("unstable_retry", int'(retry_cnt), 0);
        wait_cyc(r + 22);
        chk("unstable_run_retry", int'(retry_cnt), 0);

        // Restart coincident with locked_s dropping in RUN: no loss counted.
        q = r + 25;
        wait_cyc(q);
        pll_locked = 1'b0;
        wait_cyc(q + 2);
        restart_req = 1'b1;
        push(0, q + 3);
        push(1, q + 7);
        push(2, q + 8);
        push(3, q + 16);
        wait_cyc(q + 3);
        restart_req = 1'b0;
        wait_cyc(q + 4);
        pll_locked = 1'b1;
        chk("simul_lost", int'(lost_cnt), 1);

        // 256 loss-of-lock events: lost_cnt saturates at 255.
        t = q + 17;
        for (int i = 0; i < 256; i++) begin
            wait_cyc(t);
            pll_locked = 1'b0;
            push(0, t + 3);
            push(1, t + 7);
            push(2, t + 8);
            push(3, t + 16);
            wait_cyc(t + 4);
            pll_locked = 1'b1;
            chk("lost_sat", int'(lost_cnt), (i + 2 > 255) ? 255 : i + 2);
            t = t + 17;
        end

        // Async reset in STABLE_CHK, no clock edge needed.
        wait_cyc(t);
        pll_locked = 1'b0;
        push(0, t + 3);
        push(1, t + 7);
        push(2, t + 8);
        wait_cyc(t + 4);
        pll_locked = 1'b1;
        wait_cyc(t + 10);
        chk("pre_areset_state", int'(state_dbg), 2);
        push(0, t + 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_state", int'(state_dbg), 0);
        chk("areset_pll_rst", int'(pll_rst), 1);
        chk("areset_out_rst_n", int'(out_rst_n), 0);
        chk("areset_ready", int'(ready), 0);
        chk("areset_fault", int'(fault), 0);
        chk("areset_retry", int'(retry_cnt), 0);
        chk("areset_lost", int'(lost_cnt), 0);
        wait_cyc(t + 12);
        rst_n = 1'b1;
        wait_cyc(t + 14);
        chk("post_areset_lost", int'(lost_cnt), 0);
        chk("sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
